// File: rtl/mario_sprite_unit.sv
// Player sprite front end: per-pixel hit test, sprite-ROM addressing, frame-locked
// position/animation state and colour-key transparency for the colour mapper.
module mario_sprite_unit #(
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 32,
  parameter int          NUM_FRAMES  = 4,
  parameter int          ANIM_DIV    = 6,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
  parameter int          ADDR_W      = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        mario_x,
  input  logic [9:0]        mario_y,
  input  logic              facing_left,
  input  logic              walking,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              mario,
  output logic [23:0]       mario_pic_out,
  output logic [9:0]        DrawX_d,
  output logic [9:0]        DrawY_d
);

  localparam int CNT_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FIDX_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

  logic              fsync_p0, fsync_p1, fsync_p2;
  logic              frame_tick;
  logic [9:0]        sx, sy;
  logic              sfacing;
  logic [CNT_W-1:0]  anim_cnt;
  logic [FIDX_W-1:0] frame_idx;

  logic [10:0]       x_end, y_end;
  logic              hit_c;
  logic [9:0]        col_raw, col, row;
  logic [ADDR_W-1:0] addr_c;
  logic              hit_p0;

  // frame_clk crosses into Clk through two flops; the third flop feeds the edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync_p0 <= 1'b0;
      fsync_p1 <= 1'b0;
      fsync_p2 <= 1'b0;
    end else begin
      fsync_p0 <= frame_clk;
      fsync_p1 <= fsync_p0;
      fsync_p2 <= fsync_p1;
    end
  end

  assign frame_tick = fsync_p1 & ~fsync_p2;

  // Position and animation only move on frame_tick so a frame never tears
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sx        <= '0;
      sy        <= '0;
      sfacing   <= 1'b0;
      anim_cnt  <= '0;
      frame_idx <= '0;
    end else if (frame_tick) begin
      sx      <= mario_x;
      sy      <= mario_y;
      sfacing <= facing_left;
      if (!walking) begin
        frame_idx <= '0;
        anim_cnt  <= '0;
      end else if (frame_idx == '0) begin
        frame_idx <= FIDX_W'(1);
        anim_cnt  <= '0;
      end else if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
        anim_cnt  <= '0;
        frame_idx <= (frame_idx == FIDX_W'(NUM_FRAMES - 1)) ? FIDX_W'(1)
                                                             : frame_idx + FIDX_W'(1);
      end else begin
        anim_cnt <= anim_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 0: hit test uses 11-bit bounds so sprites at the right/bottom edge never wrap
  always_comb begin
    x_end   = {1'b0, sx} + 11'(SPRITE_W);
    y_end   = {1'b0, sy} + 11'(SPRITE_H);
    hit_c   = (DrawX >= sx) && ({1'b0, DrawX} < x_end) &&
              (DrawY >= sy) && ({1'b0, DrawY} < y_end);
    col_raw = DrawX - sx;
    row     = DrawY - sy;
    col     = sfacing ? (10'(SPRITE_W - 1) - col_raw) : col_raw;
    addr_c  = ADDR_W'(frame_idx) * ADDR_W'(FRAME_PIX) +
              ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_p0   <= 1'b0;
      DrawX_d  <= '0;
      DrawY_d  <= '0;
    end else begin
      if (hit_c) rom_addr <= addr_c;
      hit_p0  <= hit_c;
      DrawX_d <= DrawX;
      DrawY_d <= DrawY;
    end
  end

  // Stage 1: ROM data arrives aligned with hit_p0; the colour key masks the pixel
  assign mario         = hit_p0 && (rom_data != TRANSPARENT);
  assign mario_pic_out = mario ? rom_data : 24'h0;

endmodule

// File: tb/tb_mario_sprite_unit.sv
// Scoreboard bench for mario_sprite_unit: a behavioural ROM and a frame/position
// model predict every registered pixel result.
module tb_mario_sprite_unit;
  localparam logic [23:0] TRANS = 24'hFF00FF;

  logic        Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, mario_x = '0, mario_y = '0;
  logic        facing_left = 1'b0, walking = 1'b0;
  logic [10:0] rom_addr;
  logic [23:0] rom_data;
  logic        mario;
  logic [23:0] mario_pic_out;
  logic [9:0]  DrawX_d, DrawY_d;

  int checks = 0, failures = 0;

  logic        rom_fix_en = 1'b0;
  logic [23:0] rom_fix = '0;

  int m_sx = 0, m_sy = 0, m_face = 0, m_fidx = 0, m_cnt = 0, m_addr = 0;

  typedef struct {
    logic [10:0] addr;
    logic        mario;
    logic [23:0] pic;
    logic [9:0]  dx;
    logic [9:0]  dy;
  } exp_t;
  exp_t sb[$];

  mario_sprite_unit dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .mario_x(mario_x), .mario_y(mario_y),
    .facing_left(facing_left), .walking(walking),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mario(mario), .mario_pic_out(mario_pic_out),
    .DrawX_d(DrawX_d), .DrawY_d(DrawY_d)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_f(input logic [10:0] a);
    return (a[2:0] == 3'd5) ? TRANS : (24'hE52521 ^ {13'd0, a});
  endfunction

  always_comb rom_data = rom_fix_en ? rom_fix : rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_face = 0; m_fidx = 0; m_cnt = 0; m_addr = 0;
  endtask

  // Asynchronous frame strobe with random phase and widths; model follows one tick per rise
  task automatic frame_pulse();
    #($urandom_range(1, 9));
    frame_clk = 1'b1;
    #($urandom_range(25, 60));
    frame_clk = 1'b0;
    #($urandom_range(25, 60));
    m_sx = int'(mario_x); m_sy = int'(mario_y); m_face = int'(facing_left);
    if (!walking) begin
      m_fidx = 0; m_cnt = 0;
    end else if (m_fidx == 0) begin
      m_fidx = 1; m_cnt = 0;
    end else if (m_cnt == 5) begin
      m_cnt = 0;
      m_fidx = (m_fidx == 3) ? 1 : m_fidx + 1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive_pix(input int x, input int y);
    exp_t e, o;
    logic hit;
    int col, row;
    logic [23:0] rv;
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    hit = (x >= m_sx) && (x < m_sx + 16) && (y >= m_sy) && (y < m_sy + 32);
    if (hit) begin
      col = x - m_sx;
      if (m_face != 0) col = 15 - col;
      row = y - m_sy;
      m_addr = m_fidx * 512 + row * 16 + col;
    end
    e.addr  = 11'(m_addr);
    rv      = rom_fix_en ? rom_fix : rom_f(e.addr);
    e.mario = hit && (rv != TRANS);
    e.pic   = e.mario ? rv : 24'h0;
    e.dx    = 10'(x);
    e.dy    = 10'(y);
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(o.addr));
      chk("mario", 32'(mario), 32'(o.mario));
      chk("pic", 32'(mario_pic_out), 32'(o.pic));
      chk("DrawX_d", 32'(DrawX_d), 32'(o.dx));
      chk("DrawY_d", 32'(DrawY_d), 32'(o.dy));
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_mario", 32'(mario), 32'd0);
    chk("rst_dxd", 32'(DrawX_d), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    // position latch, unmirrored
    mario_x = 10'd100; mario_y = 10'd200;
    frame_pulse();
    drive_pix(100, 200); chk("addr_origin", 32'(rom_addr), 32'd0);
    drive_pix(115, 231); chk("addr_last", 32'(rom_addr), 32'd511);
    drive_pix(116, 231); chk("miss_right", 32'(mario), 32'd0);
    drive_pix(107, 199);
    drive_pix(107, 232);

    // mirrored, then colour key
    facing_left = 1'b1;
    frame_pulse();
    drive_pix(100, 200); chk("addr_mirror", 32'(rom_addr), 32'd15);
    rom_fix_en = 1'b1; rom_fix = TRANS;
    drive_pix(100, 200); chk("key_mario", 32'(mario), 32'd0);
    rom_fix = 24'hE52521;
    drive_pix(100, 200); chk("opaque_pic", 32'(mario_pic_out), 32'hE52521);
    rom_fix_en = 1'b0;

    // walk cycle
    facing_left = 1'b0; walking = 1'b1;
    frame_pulse();
    drive_pix(100, 200); chk("walk_f1", 32'(rom_addr), 32'd512);
    repeat (5) frame_pulse();
    drive_pix(100, 200); chk("walk_f1_hold", 32'(rom_addr), 32'd512);
    frame_pulse();
    drive_pix(100, 200); chk("walk_f2", 32'(rom_addr), 32'd1024);
    repeat (6) frame_pulse();
    drive_pix(100, 200); chk("walk_f3", 32'(rom_addr), 32'd1536);
    repeat (6) frame_pulse();
    drive_pix(100, 200); chk("walk_wrap", 32'(rom_addr), 32'd512);
    walking = 1'b0;
    frame_pulse();
    drive_pix(100, 200); chk("walk_stop", 32'(rom_addr), 32'd0);

    // right edge without wrap, and mid-frame position change
    mario_x = 10'd630;
    frame_pulse();
    drive_pix(639, 210); chk("edge_addr", 32'(rom_addr), 32'd169);
    drive_pix(0, 210);   chk("edge_nowrap", 32'(mario), 32'd0);
    mario_x = 10'd300;
    drive_pix(300, 210); chk("no_tear_miss", 32'(mario), 32'd0);
    drive_pix(631, 205);
    frame_pulse();
    drive_pix(300, 210);
    drive_pix(631, 205);

    // reset in the middle of a line
    walking = 1'b1;
    frame_pulse();
    drive_pix(305, 212);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_dxd", 32'(DrawX_d), 32'd0);
    chk("mid_rst_pic", 32'(mario_pic_out), 32'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    drive_pix(305, 212); chk("post_rst_miss", 32'(mario), 32'd0);
    drive_pix(3, 4);     chk("post_rst_origin", 32'(rom_addr), 32'd67);
    frame_pulse();
    drive_pix(305, 212); chk("post_rst_f1", 32'(rom_addr), 32'd709);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
